// File: rtl/arm_fetch_pkg.sv
// rtl/arm_fetch_pkg.sv - shared types and constants for the ARM fetch stage
package arm_fetch_pkg;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    localparam int WORD_BYTES     = 4;
    localparam int PC_READ_OFFSET = 8;

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - in-order FIFO of fetched {instr, pc} entries; flush beats push
module fetch_buffer
    import arm_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  fetch_entry_t           din,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty,
    output fetch_entry_t           head
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic           do_push;
    logic           do_pop;

    assign full  = (count == ($clog2(DEPTH)+1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // A push into a full buffer is only legal when the head leaves in the same cycle.
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && !flush && (!full || do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - ARM fetch stage: pc, ROM access, fetch buffer, redirect flush
// Optional FETCH_PERF_EN adds perf_fetched / perf_flushes counters.
module fetch_unit
    import arm_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rd,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc_plus8
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_flushes
`endif
);

    logic [31:0]            pc;
    logic                   pop;
    logic                   fetch;
    logic [$clog2(DEPTH):0] buf_count;
    logic                   buf_full;
    logic                   buf_empty;
    fetch_entry_t           buf_head;
    fetch_entry_t           buf_din;

    assign instr_valid = (buf_count != '0);
    assign pop         = !buf_empty && instr_ready;
    assign fetch       = !redirect && (!buf_full || pop);

    assign imem_addr      = pc;
    assign buf_din        = '{instr: imem_rd, pc: pc};
    assign instr          = buf_head.instr;
    assign instr_pc       = buf_head.pc;
    assign instr_pc_plus8 = buf_head.pc + 32'(PC_READ_OFFSET);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC & ~32'h3;
        end else if (redirect) begin
            pc <= redirect_pc & ~32'h3;
        end else if (fetch) begin
            pc <= pc + 32'(WORD_BYTES);
        end
    end

    fetch_buffer #(
        .DEPTH (DEPTH)
    ) u_buf (
        .clk   (clk),
        .reset (reset),
        .push  (fetch),
        .pop   (pop),
        .flush (redirect),
        .din   (buf_din),
        .count (buf_count),
        .full  (buf_full),
        .empty (buf_empty),
        .head  (buf_head)
    );

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_flushes <= '0;
        end else begin
            if (fetch) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (redirect) begin
                perf_flushes <= perf_flushes + 32'd1;
            end
        end
    end
`endif

endmodule
